// File: rtl/sprite_rom_arbiter_pkg.sv
// Shared constants for the sprite ROM arbiter: bus widths, ROM depth and the
// colour returned for fetches that fall outside the sprite image.
package sprite_pkg;

   localparam int N_REQ_DEFAULT = 4;
   localparam int ADDR_W        = 12;
   localparam int RGB_W         = 6;
   localparam int KOOPA_DEPTH   = 2760;

   localparam logic [RGB_W-1:0] TRANSPARENT_RGB = 6'b110011;

endpackage

// File: rtl/sprite_rom_arbiter_if.sv
// Requester/ROM bus of the sprite ROM arbiter. The master side is the requesters
// together with the ROM; the slave side is the arbiter.
interface sprite_rom_arbiter_if #(
   parameter int N_REQ  = sprite_pkg::N_REQ_DEFAULT,
   parameter int ADDR_W = sprite_pkg::ADDR_W,
   parameter int RGB_W  = sprite_pkg::RGB_W
);
   logic [N_REQ-1:0]        req;
   logic [N_REQ*ADDR_W-1:0] req_addr;
   logic [N_REQ-1:0]        gnt;
   logic [ADDR_W-1:0]       rom_addr;
   logic [RGB_W-1:0]        rom_rgb;
   logic [N_REQ-1:0]        rsp_valid;
   logic [RGB_W-1:0]        rsp_rgb;
   logic                    rsp_oor;

   modport master (
      output req, req_addr, rom_rgb,
      input  gnt, rom_addr, rsp_valid, rsp_rgb, rsp_oor
   );

   modport slave (
      input  req, req_addr, rom_rgb,
      output gnt, rom_addr, rsp_valid, rsp_rgb, rsp_oor
   );
endinterface

// File: rtl/sprite_rom_arbiter_rr.sv
// Round-robin grant: scans req upward from ptr (wrapping) and grants the first
// set bit, reporting the one-hot grant and the winning index.
module rr_arbiter #(
   parameter int N     = 4,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] idx,
   output logic             valid
);
   int cand_s;

   // Priority scan starting at ptr; the first hit masks all later candidates.
   always_comb begin
      gnt    = '0;
      idx    = '0;
      valid  = 1'b0;
      cand_s = 0;
      for (int i = 0; i < N; i++) begin
         cand_s = int'(ptr) + i;
         if (cand_s >= N) begin
            cand_s = cand_s - N;
         end else begin
            cand_s = cand_s;
         end
         if (!valid && req[cand_s]) begin
            gnt[cand_s] = 1'b1;
            idx         = IDX_W'(cand_s);
            valid       = 1'b1;
         end else begin
            valid = valid;
         end
      end
   end
endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one sprite ROM between N_REQ requesters: round-robin grant, a registered
// ROM address stage, and a registered response stage (two-cycle latency).
module sprite_rom_arbiter #(
   parameter int N_REQ  = sprite_pkg::N_REQ_DEFAULT,
   parameter int ADDR_W = sprite_pkg::ADDR_W,
   parameter int DEPTH  = sprite_pkg::KOOPA_DEPTH,
   parameter int RGB_W  = sprite_pkg::RGB_W
) (
   input  logic                 clk,
   input  logic                 rst,
   sprite_rom_arbiter_if.slave  bus
);
   import sprite_pkg::TRANSPARENT_RGB;

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [ADDR_W:0]   DEPTH_V  = (ADDR_W + 1)'(DEPTH);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_REQ - 1);
   localparam logic [N_REQ-1:0]  ONE_HOT0 = {{(N_REQ - 1){1'b0}}, 1'b1};

   logic [IDX_W-1:0]  ptr_r;
   logic [N_REQ-1:0]  arb_gnt_s;
   logic [IDX_W-1:0]  arb_idx_s;
   logic              arb_valid_s;
   logic              grant_s;
   logic [ADDR_W-1:0] addr_s;
   logic              oor_s;
   logic              v1_r;
   logic [IDX_W-1:0]  id1_r;
   logic              oor1_r;
   logic [ADDR_W-1:0] rom_addr_r;
   logic [N_REQ-1:0]  rsp_valid_r;
   logic [RGB_W-1:0]  rsp_rgb_r;
   logic              rsp_oor_r;

   rr_arbiter #(.N(N_REQ), .IDX_W(IDX_W)) u_rr (
      .req   (bus.req),
      .ptr   (ptr_r),
      .gnt   (arb_gnt_s),
      .idx   (arb_idx_s),
      .valid (arb_valid_s)
   );

   // Grant is suppressed while in reset so nothing is accepted then.
   always_comb begin
      grant_s = arb_valid_s & ~rst;
      addr_s  = bus.req_addr[int'(arb_idx_s)*ADDR_W +: ADDR_W];
      oor_s   = ({1'b0, addr_s} >= DEPTH_V);
      if (rst) begin
         bus.gnt = '0;
      end else begin
         bus.gnt = arb_gnt_s;
      end
   end

   // Round-robin pointer: moves past the winner, holds when nobody is granted.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_r <= '0;
      end else if (grant_s) begin
         ptr_r <= (arb_idx_s == LAST_IDX) ? '0 : arb_idx_s + IDX_W'(1);
      end else begin
         ptr_r <= ptr_r;
      end
   end

   // Stage 1: latch the ROM address; out-of-range fetches read address 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         v1_r       <= 1'b0;
         id1_r      <= '0;
         oor1_r     <= 1'b0;
         rom_addr_r <= '0;
      end else if (grant_s) begin
         v1_r       <= 1'b1;
         id1_r      <= arb_idx_s;
         oor1_r     <= oor_s;
         rom_addr_r <= oor_s ? '0 : addr_s;
      end else begin
         v1_r       <= 1'b0;
      end
   end

   // Stage 2: capture the ROM colour (or transparent) and strobe the owner.
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid_r <= '0;
         rsp_rgb_r   <= '0;
         rsp_oor_r   <= 1'b0;
      end else begin
         rsp_valid_r <= v1_r ? (ONE_HOT0 << id1_r) : '0;
         rsp_rgb_r   <= oor1_r ? RGB_W'(TRANSPARENT_RGB) : bus.rom_rgb;
         rsp_oor_r   <= oor1_r;
      end
   end

   assign bus.rom_addr  = rom_addr_r;
   assign bus.rsp_valid = rsp_valid_r;
   assign bus.rsp_rgb   = rsp_rgb_r;
   assign bus.rsp_oor   = rsp_oor_r;
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter: stimulus pushes expected responses into
// a queue that a separate monitor pops and checks whenever rsp_valid is seen.
module tb_sprite_rom_arbiter;
   typedef struct packed {
      logic [3:0] id;
      logic [5:0] rgb;
      logic       oor;
   } rsp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [11:0] addr_v [4];
   rsp_t        exp_q [$];
   int          checks = 0;
   int          errors = 0;
   logic [5:0]  crgb [4];
   logic        coor [4];

   sprite_rom_arbiter_if #(.N_REQ(4), .ADDR_W(12), .RGB_W(6)) bus ();

   sprite_rom_arbiter #(.N_REQ(4), .ADDR_W(12), .DEPTH(2760), .RGB_W(6)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // ROM model: colour = low six address bits XOR high six address bits.
   always_comb begin
      logic [11:0] a;
      a = bus.rom_addr;
      bus.rom_rgb = a[5:0] ^ a[11:6];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock cycle: apply req, check the combinational grant, queue the response.
   task automatic cycle(input logic [3:0] r, input logic [3:0] exp_gnt, input logic push,
                        input logic [5:0] exp_rgb, input logic exp_oor, input string name);
      rsp_t e;
      bus.req      = r;
      bus.req_addr = {addr_v[3], addr_v[2], addr_v[1], addr_v[0]};
      #1;
      chk(name, 32'(bus.gnt), 32'(exp_gnt));
      if (push) begin
         e.id  = exp_gnt;
         e.rgb = exp_rgb;
         e.oor = exp_oor;
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   // Monitor: every response strobe must match the oldest queued expectation.
   initial begin
      rsp_t e;
      forever begin
         @(negedge clk);
         if (bus.rsp_valid !== 4'b0000) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_rsp: got rsp_valid %b expected none at %0t", bus.rsp_valid, $time);
            end else begin
               e = exp_q.pop_front();
               chk("rsp_valid", 32'(bus.rsp_valid), 32'(e.id));
               chk("rsp_rgb", 32'(bus.rsp_rgb), 32'(e.rgb));
               chk("rsp_oor", 32'(bus.rsp_oor), 32'(e.oor));
            end
         end
      end
   end

   initial begin
      addr_v = '{12'd0, 12'd0, 12'd0, 12'd0};
      bus.req = 4'b0000;
      bus.req_addr = '0;
      @(posedge clk);
      #1;

      // Reset: grant forced low even with every requester asking.
      for (int i = 0; i < 3; i++) cycle(4'b1111, 4'b0000, 1'b0, 6'd0, 1'b0, "gnt_in_reset");
      chk("reset_rom_addr", 32'(bus.rom_addr), 32'd0);
      chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("reset_rsp_rgb", 32'(bus.rsp_rgb), 32'd0);
      chk("reset_rsp_oor", 32'(bus.rsp_oor), 32'd0);
      rst = 1'b0;

      // Single request to address 5; ROM[5] = 5.
      addr_v[0] = 12'd5;
      cycle(4'b0001, 4'b0001, 1'b1, 6'd5, 1'b0, "single_gnt");
      chk("single_rom_addr", 32'(bus.rom_addr), 32'd5);

      // Idle: nothing granted, ROM address held.
      for (int i = 0; i < 10; i++) begin
         cycle(4'b0000, 4'b0000, 1'b0, 6'd0, 1'b0, "idle_gnt");
         chk("idle_rom_addr", 32'(bus.rom_addr), 32'd5);
      end

      // Pointer is still 1 after idling, so requester 1 wins full contention.
      addr_v = '{12'd0, 12'd20, 12'd0, 12'd0};
      cycle(4'b1111, 4'b0010, 1'b1, 6'd20, 1'b0, "ptr_hold_gnt");

      // Wrap: 3 granted, then 0 beats 3 from the wrapped pointer.
      addr_v = '{12'd9, 12'd0, 12'd0, 12'd63};
      cycle(4'b1000, 4'b1000, 1'b1, 6'd63, 1'b0, "wrap_gnt3");
      cycle(4'b1001, 4'b0001, 1'b1, 6'd9, 1'b0, "wrap_gnt0");

      // Out of range boundary on requester 2 (ROM[2759] = 43 ^ 7 = 44).
      addr_v[2] = 12'd2760;
      cycle(4'b0100, 4'b0100, 1'b1, 6'b110011, 1'b1, "oor_gnt");
      chk("oor_rom_addr", 32'(bus.rom_addr), 32'd0);
      addr_v[2] = 12'd2759;
      cycle(4'b0100, 4'b0100, 1'b1, 6'd44, 1'b0, "inrange_gnt");
      chk("inrange_rom_addr", 32'(bus.rom_addr), 32'd2759);
      cycle(4'b0000, 4'b0000, 1'b0, 6'd0, 1'b0, "drain_gnt");
      cycle(4'b0000, 4'b0000, 1'b0, 6'd0, 1'b0, "drain_gnt");

      // Reset mid-flight: grant to 1 (ptr 3 -> scan 3,0,1) is discarded.
      addr_v[1] = 12'd100;
      cycle(4'b0010, 4'b0010, 1'b0, 6'd0, 1'b0, "flight_gnt");
      rst = 1'b1;
      bus.req = 4'b0000;
      #1;
      chk("flight_rsp_t1", 32'(bus.rsp_valid), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("flight_rsp_t2", 32'(bus.rsp_valid), 32'd0);
      cycle(4'b0000, 4'b0000, 1'b0, 6'd0, 1'b0, "post_reset_gnt");
      chk("flight_rsp_t3", 32'(bus.rsp_valid), 32'd0);

      // Full contention from ptr 0: order 0,1,2,3,0,1,2,3.
      addr_v = '{12'd10, 12'd20, 12'd30, 12'd2800};
      crgb = '{6'd10, 6'd20, 6'd30, 6'b110011};
      coor = '{1'b0, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 8; i++) begin
         cycle(4'b1111, 4'b0001 << (i % 4), 1'b1, crgb[i % 4], coor[i % 4], "contention_gnt");
      end

      // Re-request right after a grant counts as a new request.
      addr_v[0] = 12'd7;
      cycle(4'b0001, 4'b0001, 1'b1, 6'd7, 1'b0, "rereq_gnt_a");
      cycle(4'b0001, 4'b0001, 1'b1, 6'd7, 1'b0, "rereq_gnt_b");

      // Withdrawn request (0) is not granted and does not move the pointer.
      cycle(4'b0011, 4'b0010, 1'b1, 6'd20, 1'b0, "withdraw_gnt1");
      cycle(4'b0000, 4'b0000, 1'b0, 6'd0, 1'b0, "withdraw_idle");
      cycle(4'b1001, 4'b1000, 1'b1, 6'b110011, 1'b1, "withdraw_gnt3");

      for (int i = 0; i < 4; i++) cycle(4'b0000, 4'b0000, 1'b0, 6'd0, 1'b0, "final_idle");
      chk("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
